// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared types and widths for the sqrt core dispatch logic.
//   OPERAND_W : operand width presented to the core (two's complement).
//   ROOT_W    : root width returned by the core.
//   state_e   : dispatch FSM states.
//   res_t     : result bundle {root, cflag, oflag} as held in the output register.
package sqrt_pkg;

    localparam int unsigned OPERAND_W = 32;
    localparam int unsigned ROOT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT0,
        ST_BUSY,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic [ROOT_W-1:0] root;
        logic              cflag;
        logic              oflag;
    } res_t;

endpackage

// File: rtl/sqrt_dispatch_if.sv
// sqrt_dispatch_if: bundles the three streams around sqrt_dispatch.
//   operand stream : in_valid, in_ready, in_data
//   core handshake : sq_start, sq_operand, sq_ready, sq_result, sq_cflag, sq_oflag
//   result stream  : out_valid, out_ready, out_result, out_cflag, out_oflag
//   status         : fifo_count (operands queued, excluding the one in flight)
// Modports:
//   slave  : the dispatch block itself
//   master : the surrounding environment (producer, core, consumer)
interface sqrt_dispatch_if
    import sqrt_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
);

    logic                 in_valid;
    logic                 in_ready;
    logic [OPERAND_W-1:0] in_data;

    logic                 sq_start;
    logic [OPERAND_W-1:0] sq_operand;
    logic                 sq_ready;
    logic [ROOT_W-1:0]    sq_result;
    logic                 sq_cflag;
    logic                 sq_oflag;

    logic                 out_valid;
    logic                 out_ready;
    logic [ROOT_W-1:0]    out_result;
    logic                 out_cflag;
    logic                 out_oflag;

    logic [CW-1:0]        fifo_count;

    modport slave (
        input  in_valid, in_data,
        output in_ready,
        output sq_start, sq_operand,
        input  sq_ready, sq_result, sq_cflag, sq_oflag,
        output out_valid, out_result, out_cflag, out_oflag,
        input  out_ready,
        output fifo_count
    );

    modport master (
        output in_valid, in_data,
        input  in_ready,
        input  sq_start, sq_operand,
        output sq_ready, sq_result, sq_cflag, sq_oflag,
        input  out_valid, out_result, out_cflag, out_oflag,
        output out_ready,
        input  fifo_count
    );

endinterface

// File: rtl/sqrt_opfifo.sv
// sqrt_opfifo: synchronous FIFO holding operands awaiting dispatch.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (ignored when full)
//   pop      : drop head entry (ignored when empty)
//   wdata    : write data
//   rdata    : head entry (combinational, valid when !empty)
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module sqrt_opfifo
    import sqrt_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = OPERAND_W,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic do_push;
    logic do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sqrt_dispatch.sv
// sqrt_dispatch: upstream feeder for the sqrt core.
// Buffers operands in sqrt_opfifo, issues them one at a time to the core over
// its start/ready handshake and returns each root plus C/O flags, in order,
// on a registered valid/ready result stream.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (shared with the core)
//   bus      : sqrt_dispatch_if.slave (operand stream, core handshake,
//              result stream, fifo_count)
// Parameters:
//   DEPTH    : operand FIFO entries (power of two, >= 2)
//   CW       : fifo_count width
// Configuration macro:
//   SQRT_DISPATCH_NEGBYPASS_EN : when defined, negative operands skip the core
//   and return root 0 with cflag=1, oflag=0.
module sqrt_dispatch
    import sqrt_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    sqrt_dispatch_if.slave bus
);

    state_e               state_q, state_d;
    logic                 sq_start_q, sq_start_d;
    logic [OPERAND_W-1:0] sq_operand_q, sq_operand_d;
    logic                 out_valid_q, out_valid_d;
    res_t                 out_q, out_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [OPERAND_W-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;

    assign fifo_push = bus.in_valid && !fifo_full;

    sqrt_opfifo #(
        .DEPTH (DEPTH),
        .W     (OPERAND_W),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (bus.in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Only one operand is ever in flight, and a new one is issued only after
    // the output register has been drained, so results can never overtake or
    // overwrite each other.
    always_comb begin
        state_d      = state_q;
        sq_start_d   = 1'b0;
        sq_operand_d = sq_operand_q;
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        fifo_pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                fifo_pop = 1'b1;
`ifdef SQRT_DISPATCH_NEGBYPASS_EN
                if (fifo_rdata[OPERAND_W-1]) begin
                    out_d       = '{root: '0, cflag: 1'b1, oflag: 1'b0};
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    sq_operand_d = fifo_rdata;
                    sq_start_d   = 1'b1;
                    state_d      = ST_WAIT0;
                end
`else
                sq_operand_d = fifo_rdata;
                sq_start_d   = 1'b1;
                state_d      = ST_WAIT0;
`endif
            end

            // The core's ready is still high from its previous result while it
            // samples the start pulse; skip one cycle before trusting it.
            ST_WAIT0: begin
                state_d = ST_BUSY;
            end

            ST_BUSY: begin
                if (bus.sq_ready) begin
                    out_d       = '{root: bus.sq_result, cflag: bus.sq_cflag, oflag: bus.sq_oflag};
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = fifo_empty ? ST_IDLE : ST_ISSUE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sq_start_q   <= 1'b0;
            sq_operand_q <= '0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            sq_start_q   <= sq_start_d;
            sq_operand_q <= sq_operand_d;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.sq_start   = sq_start_q;
    assign bus.sq_operand = sq_operand_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_q.root;
    assign bus.out_cflag  = out_q.cflag;
    assign bus.out_oflag  = out_q.oflag;
    assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_sqrt_dispatch.sv
// tb_sqrt_dispatch: self-checking bench for sqrt_dispatch.
// A behavioural sqrt core answers start pulses after a random latency
// (C flag = operand negative, O flag = operand LSB for non-negative operands,
// chosen only so both flags carry distinguishable values). Expected results
// are queued when operands are pushed and compared as results are accepted.
module tb_sqrt_dispatch;
    import sqrt_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] op;
        logic [15:0] root;
        logic        c;
        logic        o;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sqrt_dispatch_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

    sqrt_dispatch #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [17:0] exp_q[$];
    logic [17:0] obs_mem[256];
    int          obs_wr = 0;
    int          obs_rd = 0;
    int          start_count = 0;
    int          busy_starts = 0;
    logic [31:0] core_op     = '0;
    logic        core_busy   = 1'b0;
    int          core_lat    = 0;
    int          lat_min     = 1;
    int          lat_max     = 6;
    vec_t        vecs[12];

    function automatic logic [15:0] isqrt(input logic [31:0] x);
        longint r = 0;
        for (int b = 15; b >= 0; b--) begin
            longint t = r | (longint'(1) << b);
            if (t * t <= longint'(x)) r = t;
        end
        return r[15:0];
    endfunction

    function automatic logic [17:0] core_res(input logic [31:0] op);
        if (op[31]) return {16'h0000, 1'b1, 1'b0};
        return {isqrt(op), 1'b0, op[0]};
    endfunction

    // Core model and result monitor; sampled on the falling edge.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            core_busy     <= 1'b0;
            bus.sq_ready  <= 1'b1;
            bus.sq_result <= '0;
            bus.sq_cflag  <= 1'b0;
            bus.sq_oflag  <= 1'b0;
        end else begin
            if (bus.sq_start) begin
                if (core_busy) busy_starts <= busy_starts + 1;
                start_count  <= start_count + 1;
                core_op      <= bus.sq_operand;
                core_busy    <= 1'b1;
                bus.sq_ready <= 1'b0;
                core_lat     <= int'($urandom_range(lat_max, lat_min));
            end else if (core_busy) begin
                if (core_lat <= 1) begin
                    {bus.sq_result, bus.sq_cflag, bus.sq_oflag} <= core_res(core_op);
                    bus.sq_ready <= 1'b1;
                    core_busy    <= 1'b0;
                end else begin
                    core_lat <= core_lat - 1;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                obs_mem[obs_wr[7:0]] <= {bus.out_result, bus.out_cflag, bus.out_oflag};
                obs_wr <= obs_wr + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [31:0] op, input logic [17:0] exp);
        int n = 0;
        while (!bus.in_ready && n < 300) begin
            step();
            n++;
        end
        if (!bus.in_ready) chk("push_timeout_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = op;
        exp_q.push_back(exp);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic consume();
        while (obs_rd != obs_wr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", exp_q.size(), 1);
            end else begin
                chk("result{root,c,o}", obs_mem[obs_rd[7:0]], exp_q.pop_front());
            end
            obs_rd++;
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            consume();
            step();
            n++;
        end
        consume();
        chk({name, "_drain_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_out_valid(input string name);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            step();
            n++;
        end
        chk({name, "_out_valid"}, bus.out_valid, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},   bus.in_ready,   1);
        chk({tag, "_sq_start"},   bus.sq_start,   0);
        chk({tag, "_sq_operand"}, bus.sq_operand, 0);
        chk({tag, "_out_valid"},  bus.out_valid,  0);
        chk({tag, "_out_result"}, bus.out_result, 0);
        chk({tag, "_out_cflag"},  bus.out_cflag,  0);
        chk({tag, "_out_oflag"},  bus.out_oflag,  0);
        chk({tag, "_fifo_count"}, bus.fifo_count, 0);
    endtask

    initial begin
        int s;
        int unstable;
        int ovcount;
        logic [17:0] held;
        logic [31:0] op;

        vecs[0]  = '{32'd0,         16'd0,     1'b0, 1'b0};
        vecs[1]  = '{32'd1,         16'd1,     1'b0, 1'b1};
        vecs[2]  = '{32'd15,        16'd3,     1'b0, 1'b1};
        vecs[3]  = '{32'd16,        16'd4,     1'b0, 1'b0};
        vecs[4]  = '{32'd65535,     16'd255,   1'b0, 1'b1};
        vecs[5]  = '{32'd1000000,   16'd1000,  1'b0, 1'b0};
        vecs[6]  = '{32'd144,       16'd12,    1'b0, 1'b0};
        vecs[7]  = '{32'd99,        16'd9,     1'b0, 1'b1};
        vecs[8]  = '{32'd2,         16'd1,     1'b0, 1'b0};
        vecs[9]  = '{32'h7FFF_FFFF, 16'd46340, 1'b0, 1'b1};
        vecs[10] = '{32'h4000_0000, 16'd32768, 1'b0, 1'b0};
        vecs[11] = '{32'hFFFF_FFF7, 16'd0,     1'b1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset values while held in reset.
        repeat (3) step();
        check_reset_values("rst");
        rst = 1'b0;
        step();

        // Single operand 144: start is a registered single pulse two cycles after the push edge.
        s = start_count;
        push_op(vecs[6].op, {vecs[6].root, vecs[6].c, vecs[6].o});
        chk("t144_start_e0", bus.sq_start, 0);
        step();
        chk("t144_start_e1", bus.sq_start, 0);
        step();
        chk("t144_start_e2", bus.sq_start, 1);
        chk("t144_operand", bus.sq_operand, 144);
        step();
        chk("t144_start_e3", bus.sq_start, 0);
        drain("t144", 100);
        chk("t144_start_count", start_count - s, 1);

        // Burst with consumer stalled: 1 in flight + DEPTH queued, then in_ready drops.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_op(vecs[i].op, {vecs[i].root, vecs[i].c, vecs[i].o});
        wait_out_valid("burst");
        chk("burst_fifo_count", bus.fifo_count, DEPTH);
        chk("burst_in_ready", bus.in_ready, 0);
        held = {bus.out_result, bus.out_cflag, bus.out_oflag};
        s = start_count;
        unstable = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!bus.out_valid || {bus.out_result, bus.out_cflag, bus.out_oflag} != held) unstable++;
        end
        chk("hold_unstable_cycles", unstable, 0);
        chk("hold_no_new_start", start_count - s, 0);
        bus.out_ready = 1'b1;
        push_op(vecs[5].op, {vecs[5].root, vecs[5].c, vecs[5].o});
        drain("burst", 400);

        // Remaining table vectors.
        for (int i = 7; i < 11; i++) push_op(vecs[i].op, {vecs[i].root, vecs[i].c, vecs[i].o});
        drain("table", 400);

        // Negative operand -9.
        s = start_count;
        push_op(vecs[11].op, {vecs[11].root, vecs[11].c, vecs[11].o});
`ifdef SQRT_DISPATCH_NEGBYPASS_EN
        step();
        step();
        chk("neg_bypass_out_valid", bus.out_valid, 1);
`endif
        drain("neg", 100);
`ifdef SQRT_DISPATCH_NEGBYPASS_EN
        chk("neg_start_count", start_count - s, 0);
`else
        chk("neg_start_count", start_count - s, 1);
`endif

        // Simultaneous push and pop at count 2.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op = $urandom_range(100000, 0);
            push_op(op, core_res(op));
        end
        wait_out_valid("pp");
        chk("pp_count_before", bus.fifo_count, 2);
        bus.out_ready = 1'b1;
        step();
        op = 32'd4096;
        bus.in_valid = 1'b1;
        bus.in_data  = op;
        exp_q.push_back(core_res(op));
        step();
        bus.in_valid = 1'b0;
        chk("pp_count_after", bus.fifo_count, 2);
        drain("pp", 200);

        // Pointer wrap over 3*DEPTH operands, negatives included.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            op = $urandom();
            push_op(op, core_res(op));
        end
        drain("wrap", 600);

        // Reset while the core is busy with 3 operands queued.
        lat_min = 30;
        lat_max = 30;
        for (int i = 0; i < 4; i++) push_op(32'd400 + i, core_res(32'd400 + i));
        step();
        step();
        chk("rstbusy_count", bus.fifo_count, 3);
        chk("rstbusy_core_busy", core_busy, 1);
        rst = 1'b1;
        #1;
        check_reset_values("rstbusy");
        exp_q.delete();
        step();
        obs_rd = obs_wr;
        rst = 1'b0;
        lat_min = 1;
        lat_max = 6;
        s = start_count;
        ovcount = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.out_valid) ovcount++;
        end
        chk("post_rst_out_valid_cycles", ovcount, 0);
        chk("post_rst_starts", start_count - s, 0);
        chk("post_rst_obs", obs_wr - obs_rd, 0);

        // Recovery after reset.
        push_op(32'd169, core_res(32'd169));
        drain("recover", 100);

        chk("start_while_busy", busy_starts, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sqrt_dispatch.md
# sqrt_dispatch

Upstream feeder for the `sqrt` core. Accepts 32-bit operands over a valid/ready stream and buffers them in a small FIFO. Issues them one at a time to the core via its `start`/`ready` handshake, then returns each 16-bit root and its C/O flags in order on a valid/ready result stream. Lets producers burst operands without tracking the core's variable busy time.

## Interface
Parameters:
- `DEPTH`, 4: operand FIFO entries; power of 2, ≥2.
- `CW`, $clog2(DEPTH)+1: occupancy counter width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: operand offered.
- `in_ready` out 1: FIFO not full.
- `in_data` in 32: operand, two's complement.
- `sq_start` out 1: one-cycle start pulse to core.
- `sq_operand` out 32: operand to core; held stable from `sq_start` until `sq_ready`.
- `sq_ready` in 1: core done; low from the cycle after `sq_start` until the result is valid.
- `sq_result` in 16, `sq_cflag` in 1, `sq_oflag` in 1: core outputs, valid while `sq_ready`=1.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer accepts.
- `out_result` out 16, `out_cflag` out 1, `out_oflag` out 1: registered result.
- `fifo_count` out CW: operands queued, excluding the one in flight.

## Operation
- FIFO: a write occurs on `in_valid && in_ready`. A pop occurs in the ISSUE state. Simultaneous push and pop leaves the count unchanged. Pushing while full is impossible because `in_ready`=0. Pointers wrap modulo DEPTH.
- FSM states:
  - **IDLE**: if FIFO not empty, go to ISSUE.
  - **ISSUE**: pop head into `sq_operand`, assert `sq_start` for one cycle, go to WAIT0.
  - **WAIT0**: one cycle, ignore `sq_ready`; go to BUSY.
  - **BUSY**: when `sq_ready`=1, capture result and flags into the output register, set `out_valid`, go to HOLD.
  - **HOLD**: when `out_valid && out_ready`, clear `out_valid`. Go to ISSUE if FIFO not empty, else IDLE.
- Only one operand is in flight. A new start is never issued while the output register is full, so results stay in order and are never dropped.
- Flags pass through unmodified from the core. Dispatch never interprets them.
- Mid-operation reset: FIFO is emptied and the FSM returns to IDLE. The core shares `rst`, so no stale `sq_ready` is consumed.

## Timing
- Reset values: `in_ready`=1, `sq_start`=0, `sq_operand`=0, `out_valid`=0, `out_result`=0, `out_cflag`=0, `out_oflag`=0, `fifo_count`=0.
- Empty FIFO, push at cycle 0 → ISSUE at cycle 1 → `sq_start` high at cycle 2 (registered).
- Result to `out_valid`: 1 cycle after `sq_ready` is sampled high in BUSY.
- Back-to-back throughput: core latency + 3 cycles per operand when `out_ready` is held 1.
- `in_ready` is combinational from `fifo_count` ≠ DEPTH. It rises in the cycle after a pop from full.
- `out_*` are held stable while `out_valid && !out_ready`.

## Configuration
- `SQRT_DISPATCH_NEGBYPASS_EN`
- **Defined:** in ISSUE, a popped operand with bit 31 = 1 does not start the core. Next cycle the FSM loads `out_result`=0, `out_cflag`=1, `out_oflag`=0, `out_valid`=1 and goes to HOLD. Saves the core's latency on negative inputs.
- **Undefined:** every operand goes to the core.

## Structure
- `sqrt_pkg`:
  - FSM state enum (IDLE, ISSUE, WAIT0, BUSY, HOLD)
  - `OPERAND_W`=32, `ROOT_W`=16
  - result-bundle struct {root, cflag, oflag}
- Sub-module `sqrt_opfifo`: parameterised synchronous FIFO with push/pop/full/empty/count. The dispatch FSM and output register stay in `sqrt_dispatch`.

## Test plan
- Single operand 144, `out_ready`=1 → `out_result`=12, flags 0. `sq_start` is a single pulse with `sq_operand`=144.
- Burst of 6 operands (0, 1, 15, 16, 65535, 1000000) with DEPTH=4 → `in_ready` drops after 4 queued plus 1 in flight. Results 0, 1, 3, 4, 255, 1000 come out in order.
- `out_ready` held 0 for 50 cycles after first result → `out_*` stable, no second `sq_start` until accepted.
- Operand -9: with macro undefined, the core's `sq_cflag`=1 is passed to `out_cflag`=1. With macro defined, `sq_start` never pulses and the result is 0 with cflag=1 within 2 cycles of pop.
- `rst` asserted during BUSY with 3 queued → all outputs at reset values, `fifo_count`=0, no `out_valid` after release.
- Simultaneous push and pop at count 2 → `fifo_count` stays 2. Pointer wrap over 3×DEPTH operands preserves order.
